// File: rtl/frame_max8_if.sv
// Stream bundle for frame_max8: sample input channel plus frame-result output channel.
// Optional FRAME_MAX8_MIN_EN adds the frame minimum and its index to the result channel.
interface frame_max8_if #(
  parameter int unsigned IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_max;
  logic [IDX_W-1:0] out_idx;
`ifdef FRAME_MAX8_MIN_EN
  logic [7:0]       out_min;
  logic [IDX_W-1:0] out_min_idx;
`endif

  // Block side: consumes samples, produces frame results.
  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef FRAME_MAX8_MIN_EN
    output out_min, out_min_idx,
`endif
    output in_ready, out_valid, out_max, out_idx
  );

  // Environment side: produces samples, consumes frame results.
  modport master (
    output in_valid, in_data, out_ready,
`ifdef FRAME_MAX8_MIN_EN
    input  out_min, out_min_idx,
`endif
    input  in_ready, out_valid, out_max, out_idx
  );
endinterface

// File: rtl/frame_max8.sv
// frame_max8: groups an 8-bit sample stream into frames of FRAME_LEN samples and
// reports each frame's maximum (last occurrence on ties) and its 0-based index.
// Optional macro FRAME_MAX8_MIN_EN also reports the minimum (last occurrence on ties).

// Unsigned 8-bit a >= b comparator.
module gteq8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       y
);
  assign y = (a >= b);
endmodule

module frame_max8 #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  frame_max8_if.slave bus
);
  typedef enum logic [1:0] {FIRST, ACC, HOLD} state_t;

  localparam int unsigned    LAST     = FRAME_LEN - 1;
  localparam logic [IDX_W:0] LAST_CNT = LAST[IDX_W:0];

  state_t           state;
  logic [IDX_W:0]   count;
  logic [7:0]       cur_max;
  logic [IDX_W-1:0] cur_idx;
  logic             valid_q;
  logic [7:0]       max_q;
  logic [IDX_W-1:0] idx_q;

  logic             rdy;
  logic             accept;
  logic             last;
  logic             ge_max;
  logic [7:0]       nxt_max;
  logic [IDX_W-1:0] nxt_idx;

  gteq8 u_gteq_max (.a(bus.in_data), .b(cur_max), .y(ge_max));

`ifdef FRAME_MAX8_MIN_EN
  logic [7:0]       cur_min;
  logic [IDX_W-1:0] cur_min_idx;
  logic [7:0]       min_q;
  logic [IDX_W-1:0] min_idx_q;
  logic             le_min;
  logic [7:0]       nxt_min;
  logic [IDX_W-1:0] nxt_min_idx;

  gteq8 u_gteq_min (.a(cur_min), .b(bus.in_data), .y(le_min));

  // Next running minimum including the sample offered this cycle.
  always_comb begin
    nxt_min     = cur_min;
    nxt_min_idx = cur_min_idx;
    if (state == FIRST || le_min) begin
      nxt_min     = bus.in_data;
      nxt_min_idx = (state == FIRST) ? '0 : count[IDX_W-1:0];
    end
  end

  assign bus.out_min     = min_q;
  assign bus.out_min_idx = min_idx_q;
`endif

  assign rdy          = (state != HOLD);
  assign accept       = bus.in_valid && rdy;
  assign bus.in_ready = rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_max  = max_q;
  assign bus.out_idx  = idx_q;

  // Next running maximum including the sample offered this cycle, and frame-end detect.
  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
    last    = 1'b0;
    if (state == FIRST) begin
      nxt_max = bus.in_data;
      nxt_idx = '0;
      last    = (FRAME_LEN == 1);
    end else begin
      if (ge_max) begin
        nxt_max = bus.in_data;
        nxt_idx = count[IDX_W-1:0];
      end
      last = (count == LAST_CNT);
    end
  end

  // Frame FSM: accumulate in FIRST/ACC, present and hold the result in HOLD.
  // count is always 0 in FIRST, so count+1 gives the first-sample load of 1;
  // a FRAME_LEN=1 frame leaves count at 0, which is never observed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FIRST;
      count     <= '0;
      cur_max   <= '0;
      cur_idx   <= '0;
      valid_q   <= 1'b0;
      max_q     <= '0;
      idx_q     <= '0;
`ifdef FRAME_MAX8_MIN_EN
      cur_min     <= '0;
      cur_min_idx <= '0;
      min_q       <= '0;
      min_idx_q   <= '0;
`endif
    end else begin
      case (state)
        FIRST, ACC: begin
          if (accept) begin
            cur_max <= nxt_max;
            cur_idx <= nxt_idx;
`ifdef FRAME_MAX8_MIN_EN
            cur_min     <= nxt_min;
            cur_min_idx <= nxt_min_idx;
`endif
            if (last) begin
              count   <= '0;
              state   <= HOLD;
              valid_q <= 1'b1;
              max_q   <= nxt_max;
              idx_q   <= nxt_idx;
`ifdef FRAME_MAX8_MIN_EN
              min_q     <= nxt_min;
              min_idx_q <= nxt_min_idx;
`endif
            end else begin
              count <= count + 1'b1;
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= FIRST;
          end
        end
        default: state <= FIRST;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_max8.sv
// Self-checking bench for frame_max8: one FRAME_LEN=4 and one FRAME_LEN=1 instance
// share the same stimulus; each is checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_frame_max8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       mon_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_max8_if #(.IDX_W(2)) b4 ();
  frame_max8_if #(.IDX_W(1)) b1 ();

  assign b4.in_valid  = in_valid;
  assign b4.in_data   = in_data;
  assign b4.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;

  frame_max8 #(.FRAME_LEN(4), .IDX_W(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  frame_max8 #(.FRAME_LEN(1), .IDX_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference model, one slot per DUT.
  int         flen [2] = '{4, 1};
  logic [7:0] fbuf [2][256];
  int         n    [2] = '{0, 0};
  bit         pend [2] = '{0, 0};
  int         emax [2], eidx [2], emin [2], emidx [2];
  int         frames [2] = '{0, 0};

  // Compare outputs against the model, then advance the model by one clock edge.
  task automatic step(input int d, input logic ov, input logic ir, input logic [7:0] om,
                      input int oi, input logic [7:0] omn, input int omni);
    int mx, mn;
    check($sformatf("d%0d out_valid", d), ov, pend[d]);
    check($sformatf("d%0d in_ready", d), ir, !pend[d]);
    if (pend[d]) begin
      check($sformatf("d%0d out_max", d), om, emax[d]);
      check($sformatf("d%0d out_idx", d), oi, eidx[d]);
`ifdef FRAME_MAX8_MIN_EN
      check($sformatf("d%0d out_min", d), omn, emin[d]);
      check($sformatf("d%0d out_min_idx", d), omni, emidx[d]);
`endif
    end
    if (!rst_n) begin
      n[d]    = 0;
      pend[d] = 0;
    end else if (pend[d]) begin
      if (out_ready) begin
        pend[d] = 0;
        frames[d]++;
      end
    end else if (in_valid) begin
      fbuf[d][n[d]] = in_data;
      n[d]++;
      if (n[d] == flen[d]) begin
        mx = 0;
        mn = 255;
        for (int i = 0; i < flen[d]; i++) begin
          if (fbuf[d][i] > mx) mx = fbuf[d][i];
          if (fbuf[d][i] < mn) mn = fbuf[d][i];
        end
        for (int i = 0; i < flen[d]; i++) begin
          if (fbuf[d][i] == mx) eidx[d] = i;
          if (fbuf[d][i] == mn) emidx[d] = i;
        end
        emax[d] = mx;
        emin[d] = mn;
        pend[d] = 1;
        n[d]    = 0;
      end
    end
  endtask

  // Observe both DUTs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef FRAME_MAX8_MIN_EN
      step(0, b4.out_valid, b4.in_ready, b4.out_max, int'(b4.out_idx), b4.out_min, int'(b4.out_min_idx));
      step(1, b1.out_valid, b1.in_ready, b1.out_max, int'(b1.out_idx), b1.out_min, int'(b1.out_min_idx));
`else
      step(0, b4.out_valid, b4.in_ready, b4.out_max, int'(b4.out_idx), 8'h00, 0);
      step(1, b1.out_valid, b1.in_ready, b1.out_max, int'(b1.out_idx), 8'h00, 0);
`endif
    end
  end

  // Offer one sample until the FRAME_LEN=4 instance takes it, then idle for gap cycles.
  task automatic send(input logic [7:0] v, input int gap);
    logic acc;
    in_valid = 1'b1;
    in_data  = v;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = b4.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst out_max4", b4.out_max, 8'h00);
    check("rst out_idx4", b4.out_idx, 2'd0);
    check("rst out_max1", b1.out_max, 8'h00);
    check("rst out_idx1", b1.out_idx, 1'd0);
`ifdef FRAME_MAX8_MIN_EN
    check("rst out_min4", b4.out_min, 8'h00);
    check("rst out_min_idx4", b4.out_min_idx, 2'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back frame, then frame-length-1 pair.
    send(8'h12, 0); send(8'h80, 0); send(8'h05, 0); send(8'h7F, 0);
    idle(3);
    // Tie on the maximum: last occurrence wins.
    send(8'hAA, 0); send(8'h10, 0); send(8'hAA, 0); send(8'h03, 0);
    idle(3);
    // Gaps between samples.
    send(8'h00, 3); send(8'h00, 3); send(8'h00, 3); send(8'hFF, 3);
    // Downstream stall with a sample waiting.
    out_ready = 1'b0;
    send(8'h20, 0); send(8'h30, 0); send(8'h10, 0); send(8'h40, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h55, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    idle(3);
    // Reset mid-frame discards the partial frame.
    send(8'h90, 0); send(8'hF0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    idle(3);
    send(8'h3C, 0); send(8'hC3, 0);
    idle(3);

    // Randomized traffic with small-range data to provoke ties.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      rst_n     = ($urandom_range(299) != 0);
      @(posedge clk);
      #1;
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_max8.md
Name: frame_max8

Overview:
- Streaming consumer for the 8-bit `>=` comparator `gteq8`.
- Accepts a stream of unsigned 8-bit samples over a valid/ready handshake and groups them into frames of FRAME_LEN samples.
- Tracks the running maximum of each frame and its position by instantiating one `gteq8` (a = incoming sample, b = current max).
- At frame end, presents the maximum and its index on a valid/ready output port and holds them until consumed.

Parameters:
- FRAME_LEN, 8, samples per frame; legal range 1..256.
- IDX_W, 3, width of out_idx; must equal max(1, ceil(log2(FRAME_LEN))).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  8  unsigned sample.
- out_valid  output  1  frame result available.
- out_ready  input  1  downstream accepts the result.
- out_max  output  8  maximum sample of the completed frame.
- out_idx  output  IDX_W  position (0-based) of out_max within the frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Accept event: in_valid && in_ready on a rising edge. Output transfer event: out_valid && out_ready on a rising edge.
- Reset (rst_n=0 at an edge): state=FIRST, count=0, out_valid=0, out_max=0x00, out_idx=0, in_ready=1 (in_ready is combinational from state).
  - Reset mid-frame discards the partial frame.
  - Reset during HOLD drops the pending result without a transfer.
- States:
  - FIRST: no sample yet in this frame.
  - ACC: frame partially filled.
  - HOLD: result waiting for downstream.
- in_ready = 1 in FIRST and ACC, 0 in HOLD. No bypass: the sample after a frame end is never accepted in the cycle of the output transfer.
- FIRST, on accept:
  - cur_max <= in_data, cur_idx <= 0, count <= 1.
  - If FRAME_LEN=1, go to HOLD; otherwise go to ACC.
- ACC, on accept:
  - If gteq8(in_data, cur_max)=1, then cur_max <= in_data and cur_idx <= count.
  - Ties therefore report the LAST occurrence.
  - count <= count+1.
  - If count==FRAME_LEN-1, go to HOLD and count <= 0.
- No accept in FIRST or ACC: all state holds. Gaps in in_valid are allowed anywhere in a frame.
- Entering HOLD:
  - out_valid=1 on the cycle after the final sample is accepted (latency 1 cycle).
  - out_max and out_idx are registered from the final comparison, including that final sample.
- HOLD:
  - out_valid, out_max and out_idx stay stable until the output transfer.
  - On transfer: out_valid <= 0, go to FIRST; in_ready=1 on the next cycle.
  - out_max and out_idx keep their last values after the transfer; they are don't-care while out_valid=0.
- Throughput: at most one frame per FRAME_LEN+1 cycles when out_ready is held high.
- Arithmetic: unsigned only; count is IDX_W+1 bits wide so it never wraps inside a frame.
- in_data changes while in_valid=0 have no effect.

Optional Feature:
- Macro: FRAME_MAX8_MIN_EN.
- When defined:
  - Adds output ports out_min [7:0] and out_min_idx [IDX_W-1:0].
  - Minimum tracked with a second gteq8 instance, gteq8(cur_min, in_data): cur_min <= in_data when it returns 1, so ties report the last occurrence.
  - Both ports reset to 0 and follow the same FIRST-load, HOLD-stability and latency rules as out_max and out_idx.
- When undefined: the ports and the second comparator do not exist; behaviour is otherwise identical.

Test Plan (FRAME_LEN=4, IDX_W=2):
- Reset, then stream 0x12,0x80,0x05,0x7F back-to-back with out_ready=1 -> out_valid=1 one cycle after the 4th accept; out_max=0x80, out_idx=1; in_ready=0 for exactly 1 cycle.
- Frame 0xAA,0x10,0xAA,0x03 -> out_max=0xAA, out_idx=2 (last tie wins). With MIN_EN: out_min=0x03, out_min_idx=3.
- Frame 0x00,0x00,0x00,0xFF with in_valid gaps of 3 idle cycles between samples -> out_max=0xFF, out_idx=3; no sample lost or duplicated.
- Complete a frame with out_ready=0 for 5 cycles while in_valid=1 with 0x55 -> in_ready=0 and outputs stable throughout. After out_ready=1, the next frame begins with 0x55 accepted as index 0.
- Accept 0x90,0xF0, then pulse rst_n=0 for 1 cycle, then stream 0x01,0x02,0x03,0x04 -> out_valid=0 after reset; result is out_max=0x04, out_idx=3 (partial frame discarded).
- Rebuild with FRAME_LEN=1, IDX_W=1, stream 0x3C,0xC3 -> two results, 0x3C/idx0 then 0xC3/idx0, each 1 cycle after its accept.
